// File: rtl/qpmm_issue_ctrl_pkg.sv
// Field and multiplier constants for the BN254 16x16 parameter set (PARAMS_BN254_16_16).
// Shared by the issue controller and its result FIFO.
package qpmm_issue_ctrl_pkg;

   localparam int FP_W     = 256;
   localparam int QPMM_LAT = 4;

   localparam logic [FP_W-1:0] _P =
      256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

   typedef logic [FP_W-1:0] qpmm_fp_t;

   // Single conditional subtract; the multiplier output is already < 2P.
   function automatic qpmm_fp_t qpmm_canon(input qpmm_fp_t z);
      return (z >= _P) ? z - _P : z;
   endfunction

endpackage

// File: rtl/qpmm_res_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible whenever not empty.
// Overflow is prevented upstream by the credit counter, so writes are not gated here.
module qpmm_res_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);

endmodule

// File: rtl/qpmm_issue_ctrl.sv
// Credit-based issue controller wrapping a fixed-latency modular multiplier and a result FIFO.
// Define QPMM_CANON_EN to add a registered final reduction (Z >= P ? Z-P : Z) before the FIFO.
module qpmm_issue_ctrl
   import qpmm_issue_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TAG_W      = 4,
   parameter int MUL_LAT    = QPMM_LAT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [FP_W-1:0]               in_a,
   input  logic [FP_W-1:0]               in_b,
   input  logic [TAG_W-1:0]              in_tag,
   output logic [FP_W-1:0]               mul_a,
   output logic [FP_W-1:0]               mul_b,
   input  logic [FP_W-1:0]               mul_z,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [FP_W-1:0]               out_data,
   output logic [TAG_W-1:0]              out_tag,
   output logic [$clog2(FIFO_DEPTH):0]   inflight
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]    credits;
   logic             accept;
   logic             pop;
   logic [MUL_LAT:0] dl_valid;
   logic [TAG_W-1:0] dl_tag [MUL_LAT+1];

   logic             fifo_wr;
   logic [FP_W-1:0]  fifo_z;
   logic [TAG_W-1:0] fifo_tag;
   logic             fifo_empty;
   logic [FP_W+TAG_W-1:0] fifo_rd;

   // Ready comes only from the credit register, never from in_valid or out_ready.
   assign in_ready  = (credits != '0);
   assign accept    = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign inflight  = CW'(FIFO_DEPTH) - credits;

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a    <= '0;
         mul_b    <= '0;
         dl_valid <= '0;
         credits  <= CW'(FIFO_DEPTH);
      end else begin
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
         end
         dl_valid <= {dl_valid[MUL_LAT-1:0], accept};
         if (accept && !pop)      credits <= credits - 1'b1;
         else if (pop && !accept) credits <= credits + 1'b1;
      end
   end

   // Tags travel without reset; only the valid bits decide what reaches the FIFO.
   always_ff @(posedge clk) begin
      dl_tag[0] <= in_tag;
      for (int i = 1; i <= MUL_LAT; i++) dl_tag[i] <= dl_tag[i-1];
   end

`ifdef QPMM_CANON_EN
   logic             cn_valid;
   logic [FP_W-1:0]  cn_z;
   logic [TAG_W-1:0] cn_tag;

   always_ff @(posedge clk) begin
      if (rst) cn_valid <= 1'b0;
      else     cn_valid <= dl_valid[MUL_LAT];
   end

   always_ff @(posedge clk) begin
      cn_z   <= qpmm_canon(mul_z);
      cn_tag <= dl_tag[MUL_LAT];
   end

   assign fifo_wr  = cn_valid;
   assign fifo_z   = cn_z;
   assign fifo_tag = cn_tag;
`else
   assign fifo_wr  = dl_valid[MUL_LAT];
   assign fifo_z   = mul_z;
   assign fifo_tag = dl_tag[MUL_LAT];
`endif

   qpmm_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FP_W + TAG_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data ({fifo_z, fifo_tag}),
      .rd_en   (pop),
      .rd_data (fifo_rd),
      .empty   (fifo_empty)
   );

   assign out_data = fifo_rd[FP_W+TAG_W-1:TAG_W];
   assign out_tag  = fifo_rd[TAG_W-1:0];

endmodule
